// File: rtl/tdm_demux4_pkg.sv
// Shared TDM definitions: lane count, slot width, FSM encoding and slot constants.
// Used by both the TDM mux transmit side and the 1:4 demux receive side.
package tdm_pkg;

  localparam int LANES  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [SLOT_W-1:0] SLOT_L0 = 2'b00;
  localparam logic [SLOT_W-1:0] SLOT_L1 = 2'b01;
  localparam logic [SLOT_W-1:0] SLOT_L2 = 2'b10;
  localparam logic [SLOT_W-1:0] SLOT_L3 = 2'b11;

endpackage

// File: rtl/tdm_demux4_if.sv
// Bundle of the lane-serial input stream and the published frame / slot outputs.
// The slave modport is the demux view; the master modport drives the stream.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             frame_start;
  logic [WIDTH-1:0] o0;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic             frame_valid;
  logic             frame_err;
  logic             s1;
  logic             s2;

  modport master (
    output d, d_valid, frame_start,
    input  o0, o1, o2, o3, frame_valid, frame_err, s1, s2
  );

  modport slave (
    input  d, d_valid, frame_start,
    output o0, o1, o2, o3, frame_valid, frame_err, s1, s2
  );

endinterface

// File: rtl/tdm_demux4_slot_ctr.sv
// 2-bit lane slot counter: sync clear, load-1 (new frame start) and increment enable.
// Priority is clear > load-1 > enable; otherwise the slot holds.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              en,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_r;

  // Slot register update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_r <= SLOT_L0;
    end else if (clr) begin
      slot_r <= SLOT_L0;
    end else if (load1) begin
      slot_r <= SLOT_L1;
    end else if (en) begin
      slot_r <= slot_r + 2'b01;
    end else begin
      slot_r <= slot_r;
    end
  end

  assign slot = slot_r;

endmodule

// File: rtl/tdm_demux4.sv
// 1:4 time-division demultiplexer: steers lane-serial beats into shadow registers and
// publishes all four lanes as one registered frame with a valid pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux4_if.slave bus
);

  state_e            state_r;
  logic [WIDTH-1:0]  shadow0_r;
  logic [WIDTH-1:0]  shadow1_r;
  logic [WIDTH-1:0]  shadow2_r;
  logic [WIDTH-1:0]  o0_r;
  logic [WIDTH-1:0]  o1_r;
  logic [WIDTH-1:0]  o2_r;
  logic [WIDTH-1:0]  o3_r;
  logic              frame_valid_r;
  logic              frame_err_r;
  logic [SLOT_W-1:0] slot_s;
  logic              run_beat_s;
  logic              last_beat_s;
  logic              ctr_clr_s;
  logic              ctr_load1_s;
  logic              ctr_en_s;

  // A frame_start beat always restarts at lane 0, in either state.
  assign run_beat_s  = bus.d_valid && !bus.frame_start && (state_r == RUN);
  assign last_beat_s = run_beat_s && (slot_s == SLOT_L3);
  assign ctr_clr_s   = last_beat_s;
  assign ctr_load1_s = bus.d_valid && bus.frame_start;
  assign ctr_en_s    = run_beat_s && (slot_s != SLOT_L3);

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr_s),
    .load1 (ctr_load1_s),
    .en    (ctr_en_s),
    .slot  (slot_s)
  );

  // FSM, shadow capture, frame publication and pulse generation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      shadow0_r     <= {WIDTH{1'b0}};
      shadow1_r     <= {WIDTH{1'b0}};
      shadow2_r     <= {WIDTH{1'b0}};
      o0_r          <= {WIDTH{1'b0}};
      o1_r          <= {WIDTH{1'b0}};
      o2_r          <= {WIDTH{1'b0}};
      o3_r          <= {WIDTH{1'b0}};
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      if (bus.d_valid && bus.frame_start) begin
        // Restart mid-frame drops the partial frame; outputs keep the last good one.
        shadow0_r   <= bus.d;
        frame_err_r <= (state_r == RUN);
        state_r     <= RUN;
      end else if (run_beat_s) begin
        case (slot_s)
          SLOT_L1: shadow1_r <= bus.d;
          SLOT_L2: shadow2_r <= bus.d;
          SLOT_L3: begin
            o0_r          <= shadow0_r;
            o1_r          <= shadow1_r;
            o2_r          <= shadow2_r;
            o3_r          <= bus.d;
            frame_valid_r <= 1'b1;
            state_r       <= IDLE;
          end
          default: shadow0_r <= shadow0_r;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.o0          = o0_r;
  assign bus.o1          = o1_r;
  assign bus.o2          = o2_r;
  assign bus.o3          = o3_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.s1          = slot_s[1];
  assign bus.s2          = slot_s[0];

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (WIDTH=1): stimulus pushes expected frame/error events,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_tdm_demux4;

  typedef struct {
    bit         is_err;
    logic [3:0] o;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  exp_t sb_q[$];

  tdm_demux4_if #(.WIDTH(1)) bus ();

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_frame(input logic [3:0] o);
    exp_t e;
    e.is_err = 1'b0;
    e.o      = o;
    e.cyc    = cyc;
    sb_q.push_back(e);
  endtask

  task automatic expect_err(input logic [3:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.o      = held;
    e.cyc    = cyc;
    sb_q.push_back(e);
  endtask

  // One valid beat; checks the slot presented before the edge.
  task automatic beat(input logic fs, input logic dat, input logic [1:0] es);
    chk("slot", {30'd0, bus.s1, bus.s2}, {30'd0, es});
    bus.d_valid     = 1'b1;
    bus.frame_start = fs;
    bus.d           = dat;
    @(posedge clk);
    #1;
    bus.d_valid     = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic idle(input int n, input logic fs);
    for (int i = 0; i < n; i++) begin
      bus.d_valid     = 1'b0;
      bus.frame_start = fs;
      bus.d           = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.frame_start = 1'b0;
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.frame_valid || bus.frame_err) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, bus.frame_valid, bus.frame_err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_kind", {30'd0, bus.frame_valid, bus.frame_err},
              e.is_err ? 32'd1 : 32'd2);
          chk("pulse_cycle", cyc, e.cyc);
          chk("frame_out", {28'd0, bus.o0, bus.o1, bus.o2, bus.o3}, {28'd0, e.o});
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.d_valid     = 1'b1;
    bus.frame_start = 1'b1;
    bus.d           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {28'd0, bus.o0, bus.o1, bus.o2, bus.o3}, 32'd0);
    chk("rst_slot", {30'd0, bus.s1, bus.s2}, 32'd0);
    chk("rst_pulse", {30'd0, bus.frame_valid, bus.frame_err}, 32'd0);
    rst_n           = 1'b1;
    bus.d_valid     = 1'b0;
    bus.frame_start = 1'b0;
    idle(1, 1'b0);

    // One-hot frames for lanes 0..3.
    beat(1'b1, 1'b1, 2'd0); beat(1'b0, 1'b0, 2'd1); beat(1'b0, 1'b0, 2'd2); beat(1'b0, 1'b0, 2'd3);
    expect_frame(4'b1000);
    beat(1'b1, 1'b0, 2'd0); beat(1'b0, 1'b1, 2'd1); beat(1'b0, 1'b0, 2'd2); beat(1'b0, 1'b0, 2'd3);
    expect_frame(4'b0100);
    beat(1'b1, 1'b0, 2'd0); beat(1'b0, 1'b0, 2'd1); beat(1'b0, 1'b1, 2'd2); beat(1'b0, 1'b0, 2'd3);
    expect_frame(4'b0010);
    beat(1'b1, 1'b0, 2'd0); beat(1'b0, 1'b0, 2'd1); beat(1'b0, 1'b0, 2'd2); beat(1'b0, 1'b1, 2'd3);
    expect_frame(4'b0001);
    idle(2, 1'b0);

    // Gaps of 3 idle cycles, with frame_start asserted while d_valid is low.
    beat(1'b1, 1'b1, 2'd0); idle(3, 1'b1);
    beat(1'b0, 1'b0, 2'd1); idle(3, 1'b1);
    beat(1'b0, 1'b0, 2'd2); idle(3, 1'b0);
    beat(1'b0, 1'b0, 2'd3);
    expect_frame(4'b1000);
    idle(2, 1'b0);

    // Mid-frame restart: error pulse, previous frame held, then 0,1,1,1.
    beat(1'b1, 1'b1, 2'd0); beat(1'b0, 1'b1, 2'd1);
    beat(1'b1, 1'b0, 2'd2);
    expect_err(4'b1000);
    beat(1'b0, 1'b1, 2'd1); beat(1'b0, 1'b1, 2'd2); beat(1'b0, 1'b1, 2'd3);
    expect_frame(4'b0111);

    // Back-to-back frames with no bubble.
    beat(1'b1, 1'b1, 2'd0); beat(1'b0, 1'b1, 2'd1); beat(1'b0, 1'b0, 2'd2); beat(1'b0, 1'b0, 2'd3);
    expect_frame(4'b1100);
    beat(1'b1, 1'b0, 2'd0); beat(1'b0, 1'b0, 2'd1); beat(1'b0, 1'b1, 2'd2); beat(1'b0, 1'b1, 2'd3);
    expect_frame(4'b0011);
    idle(2, 1'b0);

    // Reset after two beats discards the partial frame and clears outputs.
    beat(1'b1, 1'b0, 2'd0); beat(1'b0, 1'b1, 2'd1);
    rst_n = 1'b0;
    idle(1, 1'b0);
    rst_n = 1'b1;
    chk("midrst_out", {28'd0, bus.o0, bus.o1, bus.o2, bus.o3}, 32'd0);
    beat(1'b0, 1'b1, 2'd0);
    beat(1'b1, 1'b1, 2'd0); beat(1'b0, 1'b0, 2'd1); beat(1'b0, 1'b1, 2'd2); beat(1'b0, 1'b0, 2'd3);
    expect_frame(4'b1010);
    idle(3, 1'b0);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
